// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - WIDTH-bit add/subtract rippled over NSTAGES registered chunks
// One global advance signal shifts every stage together, so backpressure stalls the whole pipe.
module pipelined_ripple_adder #(
    parameter int WIDTH      = 32,
    parameter int STAGE_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTAGES = WIDTH / STAGE_BITS;
    localparam int LAST    = NSTAGES - 1;

    generate
        if (WIDTH % STAGE_BITS != 0) begin : g_bad_split
            $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGE_BITS");
        end
    endgenerate

    logic                  v_q [NSTAGES];
    logic [WIDTH-1:0]      a_q [NSTAGES];
    logic [WIDTH-1:0]      b_q [NSTAGES];
    logic [WIDTH-1:0]      s_q [NSTAGES];
    logic                  c_q [NSTAGES];
    logic                  m_q;

    logic                  src_v [NSTAGES];
    logic [WIDTH-1:0]      src_a [NSTAGES];
    logic [WIDTH-1:0]      src_b [NSTAGES];
    logic [WIDTH-1:0]      src_s [NSTAGES];
    logic                  src_c [NSTAGES];
    logic [STAGE_BITS:0]   part  [NSTAGES];
    logic [WIDTH-1:0]      nxt_s [NSTAGES];
    logic                  m_nxt;
    logic                  adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 0 takes the operands straight from the ports; later stages take the previous register.
    always_comb begin
        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_c[0] = sub ? ~cin : cin;
        src_s[0] = '0;
        for (int k = 1; k < NSTAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end
        for (int k = 0; k < NSTAGES; k++) begin
            part[k] = {1'b0, src_a[k][k*STAGE_BITS +: STAGE_BITS]}
                    + {1'b0, src_b[k][k*STAGE_BITS +: STAGE_BITS]}
                    + {{STAGE_BITS{1'b0}}, src_c[k]};
            nxt_s[k] = src_s[k];
            nxt_s[k][k*STAGE_BITS +: STAGE_BITS] = part[k][STAGE_BITS-1:0];
        end
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
        m_nxt = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ part[LAST][STAGE_BITS-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            m_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NSTAGES; k++) begin
                v_q[k] <= src_v[k];
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                s_q[k] <= nxt_s[k];
                c_q[k] <= part[k][STAGE_BITS];
            end
            m_q <= m_nxt;
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = c_q[LAST] ^ m_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - randomized and directed checks against an arithmetic reference model
module tb_pipelined_ripple_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipelined_ripple_adder #(.WIDTH(W), .STAGE_BITS(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_out = 0;
    int last_out_cyc = 0;
    logic in_fire, out_fire;
    logic [W+1:0] last_out;
    logic [W+1:0] expq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain wide arithmetic and the sign rule for overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        logic [W-1:0] ye;
        logic [W:0]   full;
        logic         v;
        ye   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (s ? ~ci : ci)};
        v    = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
        return {v, full};
    endfunction

    // Inputs are set at the falling edge; transfers are judged just before the rising edge.
    task automatic step();
        #1;
        in_fire  = in_valid && in_ready && !rst;
        out_fire = out_valid && out_ready && !rst;
        if (out_fire) begin
            last_out = {ovf, cout, sum};
            last_out_cyc = cyc;
            n_out++;
            if (expq.size() == 0) chk("spurious_out", 64'(last_out), 64'hDEAD);
            else chk("scoreboard", 64'(last_out), 64'(expq.pop_front()));
        end
        if (in_fire) expq.push_back(model(a, b, cin, sub));
        if (rst) expq.delete();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_single(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                              input logic s, input logic [W+1:0] exp, input string tag);
        int acc;
        bit got;
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        acc = cyc;
        step();
        chk({tag, "_accept"}, 64'(in_fire), 64'd1);
        in_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (out_fire) got = 1'b1;
        end
        chk({tag, "_seen"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(last_out_cyc - acc), 64'd4);
        chk({tag, "_value"}, 64'(last_out), 64'(exp));
    endtask

    initial begin
        logic [W-1:0] oa [8];
        logic [W-1:0] ob [8];
        logic         oc [8];
        logic         os [8];
        logic [W+1:0] held;
        int i, k, start_out, t0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        step();

        run_single(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_0000}, "wrap");
        run_single(32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, "sub_neg");
        run_single(32'h8000_0000, 32'd1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}, "sub_ovf");
        run_single(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}, "add_ovf");
        run_single(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {1'b1, 1'b1, 32'h0}, "add_negovf");

        // Back-to-back stream with a three-cycle consumer stall.
        for (int j = 0; j < 8; j++) begin
            oa[j] = $urandom; ob[j] = $urandom; oc[j] = 1'($urandom); os[j] = 1'($urandom);
        end
        i = 0; k = 0; t0 = cyc; start_out = n_out; held = '0;
        while ((n_out - start_out) < 8 && k < 40) begin
            out_ready = !(k >= 5 && k <= 7);
            in_valid  = (i < 8);
            if (i < 8) begin a = oa[i]; b = ob[i]; cin = oc[i]; sub = os[i]; end
            #1;
            if (k >= 5 && k <= 7) begin
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                if (k == 5) held = {ovf, cout, sum};
                else chk("stall_hold", 64'({ovf, cout, sum}), 64'(held));
            end
            step();
            if (in_fire) i++;
            k++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", 64'(n_out - start_out), 64'd8);
        chk("stream_latency", 64'(last_out_cyc - t0), 64'd14);

        // Reset with three items in flight.
        for (int j = 0; j < 3; j++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            #1;
            chk("flushed_out_valid", 64'(out_valid), 64'd0);
            step();
        end
        run_single(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0,
                   {1'b0, 1'b0, 32'h2222_2222}, "post_rst");

        // Random traffic with random backpressure.
        i = 0;
        for (int j = 0; j < 2000 && i < 300; j++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
            step();
            if (in_fire) i++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 20 && expq.size() != 0; j++) step();
        chk("random_accepted", 64'(i), 64'd300);
        chk("drain_empty", 64'(expq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
- Parametrised successor to the team's fixed 16-bit combinational ripple-carry adder.
- Splits a WIDTH-bit add/subtract into NSTAGES = WIDTH/STAGE_BITS pipeline stages. Each stage ripples one STAGE_BITS chunk and registers the carry into the next stage.
- Adds a valid/ready handshake with backpressure, subtract mode and a signed-overflow flag.
- Sits between operand producers and result consumers in datapaths where a full-width ripple chain would miss timing.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- STAGE_BITS, 8, bits resolved per pipeline stage. WIDTH mod STAGE_BITS must be 0, otherwise elaboration fails.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. In sub mode, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Operation: b_eff = sub ? ~b : b. c0 = sub ? ~cin : cin. {cout, sum} = a + b_eff + c0, with the result modulo 2^WIDTH plus carry. So sub=1 gives a - b - cin.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Global advance signal: adv = !out_valid | out_ready. When adv=1, all stages shift one place together; when adv=0, all stage registers hold.
- in_ready = adv, purely combinational from out_valid and out_ready.
- Each stage register holds:
  - a valid bit;
  - the not-yet-added upper chunks of a and b_eff;
  - the completed lower sum chunks;
  - the running carry;
  - for the final stage, the MSB carry-in used for ovf.
- Stage k (0-based) adds chunk k, bits [k*STAGE_BITS +: STAGE_BITS], using the carry registered by stage k-1; stage 0 uses c0.
- Latency: a transfer accepted at rising edge t gives out_valid=1 after edge t+NSTAGES-1, so the result is visible in the cycle after that edge, provided adv stays 1. With the defaults this is 4 cycles from in_valid to out_valid.
- Each adv=0 cycle adds exactly one cycle of latency to every in-flight item.
- Throughput is 1 result per cycle when out_ready stays 1.
- Bubbles: if in_valid=0 while adv=1, a stage-0 entry with valid=0 enters the pipe. Bubbles never raise out_valid.
- Ordering: results leave strictly in acceptance order. No result is dropped or duplicated.
- Output stability: while out_valid=1 and out_ready=0, sum, cout and ovf hold stable.
- Reset (rst=1 at an edge): clears every stage valid bit, including mid-operation, so in-flight items are discarded.
- Outputs after reset: out_valid=0, sum=0, cout=0, ovf=0, and in_ready=1 in the cycle after reset.
- Data registers are also cleared to 0 on reset.
- While rst=1: in_valid is ignored and no transfer occurs.
- Inputs a, b, cin and sub are sampled only on a transfer edge. Values presented while in_ready=0 are ignored.
- STAGE_BITS = WIDTH: single stage, 1-cycle latency, same arithmetic as the legacy adder plus a register.
- Wrap-around: 0xFFFFFFFF + 1 gives sum=0 and cout=1, with no other side effect.

Test Plan:
- Defaults, add a=0xFFFFFFFF, b=0x00000000, cin=1, out_ready=1 -> out_valid 4 cycles later, sum=0x00000000, cout=1, ovf=0. The carry must ripple through all 4 stages.
- Sub a=5, b=7, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Sub a=0x80000000, b=1, cin=0 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Add a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1. Add a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Back-to-back stream of 8 random ops with out_ready held 0 for cycles 5-7:
  - in_ready falls with out_ready while out_valid=1;
  - outputs hold stable during the stall;
  - all 8 results match the golden model in order;
  - total latency is +3 cycles.
- Reset mid-flight:
  - accept 3 ops, assert rst for 1 cycle;
  - out_valid stays 0 and none of the 3 results ever appear;
  - the next op accepted afterwards returns the correct result after 4 cycles.
- Parametrisation runs:
  - WIDTH=16, STAGE_BITS=16: 1-cycle latency, 0xFFFF+0x0001+cin=1 -> sum=0x0001, cout=1.
  - WIDTH=64, STAGE_BITS=4: 16-cycle latency, 10k random ops match the golden model.
  - WIDTH=20, STAGE_BITS=8 must fail elaboration.
